dmem: RTL and testbench

DMEM -- requirements
Module: dmem

---
 rtl/dmem.sv | 145 ++++++++++++++
 tb/tb_dmem.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem.sv
// Single-port data memory with byte/half/word loads and stores behind a
// req/ack handshake. Define DMEM_MISALIGN_ERR_EN to report misaligned accesses via err.
`timescale 1ns/1ps

module dmem #(
  parameter int n    = 32,
  parameter int alen = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req,
  input  logic            we,
  input  logic [alen+1:0] addr,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [n-1:0]    wdata,
  output logic            ack,
  output logic [n-1:0]    rdata,
  output logic            err
);

  localparam int DEPTH = 2 ** alen;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nx;

  logic            we_q;
  logic [alen+1:0] addr_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [n-1:0]    wdata_q;

  logic [n-1:0]    mem [DEPTH];

  logic [alen-1:0] widx;
  logic [1:0]      off;
  logic            bad;
  logic [n-1:0]    cur;
  logic [n-1:0]    shifted;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [n-1:0]    load_v;
  logic [n-1:0]    merged;
  logic            mem_we;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ack = (state == RESP);
  end

  // Request capture; inputs are ignored outside IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else if (state == IDLE && req) begin
      we_q    <= we;
      addr_q  <= addr;
      size_q  <= size;
      uns_q   <= uns;
      wdata_q <= wdata;
    end
  end

  // Alignment handling: either flag the access or drop the offending offset bits.
  always_comb begin
    off = addr_q[1:0];
`ifdef DMEM_MISALIGN_ERR_EN
    bad = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    bad = 1'b0;
    if (size_q == 2'b01) off[0] = 1'b0;
    if (size_q[1])       off    = 2'b00;
`endif
  end

  always_comb begin
    widx    = addr_q[alen+1:2];
    cur     = mem[widx];
    shifted = cur >> {off, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = shifted[15:0];

    unique case (size_q)
      2'b00:   load_v = {{(n-8){~uns_q & byte_v[7]}}, byte_v};
      2'b01:   load_v = {{(n-16){~uns_q & half_v[15]}}, half_v};
      default: load_v = cur;
    endcase

    merged = cur;
    unique case (size_q)
      2'b00:   merged[{off, 3'b000} +: 8]     = wdata_q[7:0];
      2'b01:   merged[{off[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase

    mem_we = (state == ACCESS) && we_q && !bad;
  end

  // Memory array has no reset; writes only land on the ACCESS edge.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[widx] <= merged;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (state == ACCESS) begin
      rdata <= (we_q || bad) ? '0 : load_v;
      err   <= bad;
    end
  end

endmodule

// File: tb/tb_dmem.sv
// Randomized bench for dmem: byte-array reference model plus literal spot checks.
`timescale 1ns/1ps

module tb_dmem;

  localparam int N    = 32;
  localparam int ALEN = 6;
  localparam int NB   = 4 * (2 ** ALEN);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [7:0]  addr  = '0;
  logic [1:0]  size  = '0;
  logic        uns   = 1'b0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  int total = 0;
  int bad   = 0;

  dmem #(.n(N), .alen(ALEN)) dut (
    .clock(clock),
    .reset(reset),
    .req  (req),
    .we   (we),
    .addr (addr),
    .size (size),
    .uns  (uns),
    .wdata(wdata),
    .ack  (ack),
    .rdata(rdata),
    .err  (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flat byte memory, response computed when a request is accepted.
  logic [7:0]  mb [NB];
  bit          run    = 0;
  int          m      = 0;
  logic [31:0] exp_r  = '0;
  bit          exp_e  = 0;
  logic [31:0] hold_r = '0;
  bit          hold_e = 0;
  bit          pend_w = 0;
  int          pend_base;
  int          pend_nb;
  logic [31:0] pend_data;

  function automatic void issue(input bit w, input logic [7:0] a, input logic [1:0] sz,
                                input bit u, input logic [31:0] wd);
    int nb;
    logic [7:0] aa;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    aa = a;
`ifdef DMEM_MISALIGN_ERR_EN
    if ((int'(a) % nb) != 0) begin
      exp_r  = '0;
      exp_e  = 1;
      pend_w = 0;
      return;
    end
`else
    aa = a & ~8'(nb - 1);
`endif
    exp_e = 0;
    if (w) begin
      pend_w    = 1;
      pend_base = int'(aa);
      pend_nb   = nb;
      pend_data = wd;
      exp_r     = '0;
    end else begin
      pend_w = 0;
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[int'(aa) + i];
      if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      exp_r = v;
    end
  endfunction

  always @(negedge clock) begin
    if (run) begin
      if (!reset) begin
        m      = 0;
        pend_w = 0;
        hold_r = '0;
        hold_e = 0;
        check("reset_ack", 32'(ack), 32'd0);
      end else begin
        case (m)
          0: begin
            check("ack_idle", 32'(ack), 32'd0);
            if (req) begin
              issue(we, addr, size, uns, wdata);
              m = 1;
            end
          end
          1: begin
            check("ack_resp", 32'(ack), 32'd1);
            hold_r = exp_r;
            hold_e = exp_e;
            if (pend_w)
              for (int i = 0; i < pend_nb; i++) mb[(pend_base + i) % NB] = pend_data[8*i +: 8];
            pend_w = 0;
            m = 2;
          end
          default: begin
            check("ack_after", 32'(ack), 32'd0);
            m = 0;
          end
        endcase
      end
      check("rdata", rdata, hold_r);
      check("err", 32'(err), 32'(hold_e));
    end
  end

  task automatic access(input bit w, input logic [7:0] a, input logic [1:0] sz, input bit u,
                        input logic [31:0] wd, output logic [31:0] r, output logic e,
                        output int lat);
    @(negedge clock);
    #1;
    req = 1; we = w; addr = a; size = sz; uns = u; wdata = wd;
    lat = 0; r = '0; e = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (ack) begin
        lat = k; r = rdata; e = err;
        break;
      end
      #1;
      we = 1'($urandom); addr = 8'($urandom); size = 2'($urandom);
      uns = 1'($urandom); wdata = $urandom;
    end
    #1 req = 0;
    if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic e;
    int lat;
    logic [8:0] pat;
    int cnt;

    #1 reset = 0;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    run = 1;
    repeat (2) @(negedge clock);
    #1 reset = 1;

    for (int w = 0; w < NB / 4; w++) access(1, 8'(4 * w), 2'd2, 0, $urandom, r, e, lat);

    access(1, 8'h10, 2'd2, 0, 32'hDEAD_BEEF, r, e, lat);
    check("st_word_lat", 32'(lat), 32'd2);
    check("st_word_rdata", r, 32'd0);
    access(0, 8'h10, 2'd2, 0, 32'h0, r, e, lat);
    check("ld_word_lat", 32'(lat), 32'd2);
    check("ld_word", r, 32'hDEAD_BEEF);
    check("ld_word_err", 32'(e), 32'd0);

    access(1, 8'h10, 2'd2, 0, 32'h0, r, e, lat);
    access(1, 8'h11, 2'd0, 0, 32'h0000_0080, r, e, lat);
    access(0, 8'h11, 2'd0, 0, 32'h0, r, e, lat);
    check("ld_byte_signed", r, 32'hFFFF_FF80);
    access(0, 8'h11, 2'd0, 1, 32'h0, r, e, lat);
    check("ld_byte_uns", r, 32'h0000_0080);
    access(0, 8'h10, 2'd2, 0, 32'h0, r, e, lat);
    check("ld_word_after_byte", r, 32'h0000_8000);

    access(1, 8'h20, 2'd2, 0, 32'hCAFE_F00D, r, e, lat);
    access(1, 8'h22, 2'd1, 0, 32'hFFFF_1234, r, e, lat);
    access(0, 8'h20, 2'd2, 0, 32'h0, r, e, lat);
    check("ld_word_after_half", r, 32'h1234_F00D);
    access(0, 8'h22, 2'd1, 0, 32'h0, r, e, lat);
    check("ld_half_signed", r, 32'h0000_1234);
    access(0, 8'h20, 2'd1, 0, 32'h0, r, e, lat);
    check("ld_half_neg", r, 32'hFFFF_F00D);

    access(1, 8'h10, 2'd2, 0, 32'hA5A5_A5A5, r, e, lat);
    access(1, 8'h13, 2'd2, 0, 32'h1122_3344, r, e, lat);
`ifdef DMEM_MISALIGN_ERR_EN
    check("misalign_err", 32'(e), 32'd1);
    access(0, 8'h10, 2'd2, 0, 32'h0, r, e, lat);
    check("misalign_nowrite", r, 32'hA5A5_A5A5);
`else
    check("misalign_err", 32'(e), 32'd0);
    access(0, 8'h10, 2'd2, 0, 32'h0, r, e, lat);
    check("misalign_aligned", r, 32'h1122_3344);
`endif

    // Back-to-back burst with req held for nine cycles.
    pat = '0;
    cnt = 0;
    @(negedge clock);
    #1;
    req = 1; we = 1'($urandom); addr = 8'($urandom); size = 2'($urandom);
    uns = 1'($urandom); wdata = $urandom;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      pat[k-1] = ack;
      if (ack) cnt++;
      #1;
      we = 1'($urandom); addr = 8'($urandom); size = 2'($urandom);
      uns = 1'($urandom); wdata = $urandom;
    end
    req = 0;
    check("burst_count", 32'(cnt), 32'd3);
    check("burst_pattern", 32'(pat), 32'b0_1001_0010);

    for (int t = 0; t < 300; t++)
      access(1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), $urandom, r, e, lat);

    // Asynchronous reset while a store sits in ACCESS.
    access(1, 8'h30, 2'd2, 0, 32'h5A5A_0F0F, r, e, lat);
    access(0, 8'h30, 2'd2, 0, 32'h0, r, e, lat);
    check("pre_reset_load", r, 32'h5A5A_0F0F);
    @(negedge clock);
    #1;
    req = 1; we = 1; addr = 8'h30; size = 2'd2; wdata = 32'h0000_FFFF;
    @(negedge clock);
    #3 reset = 0;
    req = 0;
    #1;
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_err", 32'(err), 32'd0);
    @(negedge clock);
    #1 reset = 1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (ack) cnt++;
    end
    check("abort_no_ack", 32'(cnt), 32'd0);
    access(0, 8'h30, 2'd2, 0, 32'h0, r, e, lat);
    check("abort_mem_kept", r, 32'h5A5A_0F0F);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
